spi_cmd_scheduler: RTL

//  Takes 24-bit command frames from the SPI frame listener (one-cycle strobe plus data).

---
 rtl/spi_cmd_scheduler_pkg.sv | 27 ++
 rtl/spi_cmd_scheduler_fifo.sv | 58 +++++
 rtl/spi_cmd_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/spi_cmd_scheduler_pkg.sv
// rtl/spi_cmd_scheduler_pkg.sv - frame field layout, FSM encodings and field helpers
package spi_cmd_scheduler_pkg;

  localparam int FRAME_W  = 24;
  localparam int TGT_MSB  = 20;
  localparam int TGT_LSB  = 19;
  localparam int REG_MSB  = 18;
  localparam int REG_LSB  = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  function automatic logic [1:0] frame_tgt(input logic [FRAME_W-1:0] f);
    return f[TGT_MSB:TGT_LSB];
  endfunction

  function automatic logic [2:0] frame_reg(input logic [FRAME_W-1:0] f);
    return f[REG_MSB:REG_LSB];
  endfunction

  function automatic logic [15:0] frame_data(input logic [FRAME_W-1:0] f);
    return f[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/spi_cmd_scheduler_fifo.sv
// rtl/spi_cmd_scheduler_fifo.sv - synchronous command FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle
module spi_cmd_scheduler_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// rtl/spi_cmd_scheduler.sv - queues SPI command frames and dispatches them to register
// targets over valid/ready, tracking overflow, bad-target and timeout drops
module spi_cmd_scheduler
  import spi_cmd_scheduler_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_frame_valid,
  input  logic [FRAME_W-1:0]     i_frame_data,
  output logic [NUM_TARGETS-1:0] o_tgt_valid,
  output logic [2:0]             o_tgt_reg,
  output logic [15:0]            o_tgt_data,
  input  logic [NUM_TARGETS-1:0] i_tgt_ready,
  output logic                   o_busy,
  output logic                   o_overflow,
  output logic                   o_bad_tgt,
  output logic                   o_timeout_err,
  output logic [7:0]             o_drop_cnt,
  input  logic                   i_err_clr
);

  logic [0:0]             r_state;
  logic [NUM_TARGETS-1:0] r_tgt_valid;
  logic [2:0]             r_hold_reg;
  logic [15:0]            r_hold_data;
  logic [7:0]             r_wait;
  logic                   r_overflow;
  logic                   r_bad_tgt;
  logic                   r_timeout_err;
  logic [7:0]             r_drop_cnt;

  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [FRAME_W-1:0]     w_head;
  logic [1:0]             w_head_tgt;
  logic [NUM_TARGETS-1:0] w_onehot;
  logic                   w_head_ok;
  logic                   w_pop;
  logic                   w_done;
  logic                   w_ovf_ev;
  logic                   w_bad_ev;
  logic                   w_to_ev;
  logic [1:0]             w_drop_inc;
  logic [7:0]             w_drop_base;
  logic [8:0]             w_drop_sum;
  logic                   w_unused_tag;

  spi_cmd_scheduler_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_frame_valid),
    .i_data  (i_frame_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Tag bits are already filtered by the frame listener.
  assign w_unused_tag = ^w_head[FRAME_W-1:TGT_MSB+1];
  assign w_head_tgt   = frame_tgt(w_head);
  assign w_head_ok    = int'(w_head_tgt) < NUM_TARGETS;

  always_comb begin
    w_onehot = '0;
    for (int t = 0; t < NUM_TARGETS; t++) begin
      w_onehot[t] = (int'(w_head_tgt) == t);
    end
  end

  // r_tgt_valid is the one-hot of the selected target, so masking ignores other readies.
  assign w_pop    = (r_state == ST_IDLE) && !w_fifo_empty;
  assign w_done   = (r_state == ST_ISSUE) && |(i_tgt_ready & r_tgt_valid);
  assign w_to_ev  = (r_state == ST_ISSUE) && !w_done && (r_wait == 8'(TIMEOUT - 1));
  assign w_ovf_ev = i_frame_valid && w_fifo_full && !w_pop;
  assign w_bad_ev = w_pop && !w_head_ok;

  assign w_drop_inc  = {1'b0, w_ovf_ev} + {1'b0, w_bad_ev | w_to_ev};
  assign w_drop_base = i_err_clr ? 8'd0 : r_drop_cnt;
  assign w_drop_sum  = {1'b0, w_drop_base} + {7'd0, w_drop_inc};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_tgt_valid <= '0;
      r_hold_reg  <= '0;
      r_hold_data <= '0;
      r_wait      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop && w_head_ok) begin
            r_state     <= ST_ISSUE;
            r_tgt_valid <= w_onehot;
            r_hold_reg  <= frame_reg(w_head);
            r_hold_data <= frame_data(w_head);
            r_wait      <= '0;
          end
        end
        default: begin
          if (w_done || w_to_ev) begin
            r_state     <= ST_IDLE;
            r_tgt_valid <= '0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
      endcase
    end
  end

  // A clear and a new error in the same cycle leave the new error recorded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow    <= 1'b0;
      r_bad_tgt     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      r_overflow    <= w_ovf_ev | (r_overflow & !i_err_clr);
      r_bad_tgt     <= w_bad_ev | (r_bad_tgt & !i_err_clr);
      r_timeout_err <= w_to_ev | (r_timeout_err & !i_err_clr);
      r_drop_cnt    <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign o_tgt_valid   = r_tgt_valid;
  assign o_tgt_reg     = r_hold_reg;
  assign o_tgt_data    = r_hold_data;
  assign o_busy        = !w_fifo_empty || (r_state != ST_IDLE);
  assign o_overflow    = r_overflow;
  assign o_bad_tgt     = r_bad_tgt;
  assign o_timeout_err = r_timeout_err;
  assign o_drop_cnt    = r_drop_cnt;

endmodule
